// File: rtl/upd1771c_pkg.sv
// Shared definitions for the uPD1771C tone-path model.
// Holds the host command codes, the packet FSM state encoding,
// the timbre codes and the waveform lookup used by the tone generator.
package upd1771c_pkg;

    localparam logic [7:0] CMD_STOP = 8'h00;
    localparam logic [7:0] CMD_TONE = 8'h02;

    typedef enum logic [1:0] {
        PKT_IDLE = 2'd0,
        PKT_B1   = 2'd1,
        PKT_B2   = 2'd2,
        PKT_B3   = 2'd3
    } pkt_state_e;

    // Codes 5..7 have no name of their own and play as a square wave.
    typedef enum logic [2:0] {
        TIMBRE_SQUARE   = 3'd0,
        TIMBRE_PULSE25  = 3'd1,
        TIMBRE_PULSE12  = 3'd2,
        TIMBRE_SAW      = 3'd3,
        TIMBRE_TRIANGLE = 3'd4
    } timbre_e;

    // Waveform level 0..7 for a 5-bit phase.
    function automatic logic [2:0] wave_level(input logic [2:0] timbre,
                                              input logic [4:0] phase);
        logic [2:0] lvl;
        case (timbre)
            TIMBRE_PULSE25:  lvl = (phase < 5'd8) ? 3'd7 : 3'd0;
            TIMBRE_PULSE12:  lvl = (phase < 5'd4) ? 3'd7 : 3'd0;
            TIMBRE_SAW:      lvl = phase[4:2];
            // Falling half uses (31-ph)>>1, which is the inverted bits of ph.
            TIMBRE_TRIANGLE: lvl = phase[4] ? ~phase[3:1] : phase[3:1];
            default:         lvl = (phase < 5'd16) ? 3'd7 : 3'd0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/upd1771c_tone.sv
// Tone generator for the uPD1771C model.
// A tick divider paces a 5-bit phase counter that steps once every
// (period+1) ticks; the phase selects a waveform level which is scaled
// by the volume into an 8-bit unsigned sample.
// Ports:
//   clk, res          clock and synchronous active-high reset
//   load              load timbre/period/volume atomically, restart phase
//   stop              force period to 0 (silence)
//   timbre[2:0]       waveform select for load
//   period[7:0]       period P for load; 0 means silent
//   volume[4:0]       volume V for load
//   snd[7:0]          registered PCM sample, level * volume
module upd1771c_tone
    import upd1771c_pkg::*;
#(
    parameter int unsigned TICK_DIV = 32
) (
    input  logic       clk,
    input  logic       res,
    input  logic       load,
    input  logic       stop,
    input  logic [2:0] timbre,
    input  logic [7:0] period,
    input  logic [4:0] volume,
    output logic [7:0] snd
);

    localparam int unsigned DVW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DVW-1:0] DIV_LAST = DVW'(TICK_DIV - 1);

    logic [DVW-1:0] div;
    logic [7:0]     tick_cnt;
    logic [7:0]     period_r;
    logic [2:0]     timbre_r;
    logic [4:0]     volume_r;
    logic [4:0]     phase;
    logic           tick;
    logic [2:0]     level;

    assign tick  = (div == DIV_LAST);
    assign level = wave_level(timbre_r, phase);

    always_ff @(posedge clk) begin
        if (res) begin
            div      <= '0;
            tick_cnt <= '0;
            period_r <= '0;
            timbre_r <= '0;
            volume_r <= '0;
            phase    <= '0;
            snd      <= '0;
        end else begin
            if (load) begin
                // The divider restarts too, so every phase step of a new
                // tone lands exactly (P+1)*TICK_DIV clocks apart from load.
                timbre_r <= timbre;
                period_r <= period;
                volume_r <= volume;
                phase    <= '0;
                div      <= '0;
                tick_cnt <= '0;
            end else begin
                if (stop) begin
                    period_r <= '0;
                end
                if (tick) begin
                    div <= '0;
                    if (tick_cnt == period_r) begin
                        tick_cnt <= '0;
                        phase    <= phase + 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end else begin
                    div <= div + 1'b1;
                end
            end
            snd <= (period_r == 8'd0) ? 8'd0 : ({5'd0, level} * {3'd0, volume_r});
        end
    end

endmodule

// File: rtl/upd_1771c.sv
// NEC uPD1771C sound controller, tone path only.
// The host writes command packets on port A, strobed by /CS (PB7) and
// /WR (PB6). Multi-byte packets are paced with the DSB handshake on PB0.
// A complete tone packet (02, timbre, period, volume) loads the tone
// generator; a lone 00 silences it.
// Ports:
//   CLK, RES     system clock, synchronous active-high reset
//   CH1, CH2     clock-mode straps, ignored
//   PA_I[7:0]    host data byte
//   PA_O, PA_OE  port A output/enable, constant 0
//   PB_I[7:0]    [7]=/CS, [6]=/WR, active-low; rest ignored
//   PB_O[7:0]    [0]=DSB, others 0
//   PB_OE[7:0]   constant 8'h01
//   SND_O[7:0]   unsigned PCM sample
module upd_1771c
    import upd1771c_pkg::*;
#(
    parameter int unsigned TICK_DIV = 32,
    parameter int unsigned DSB_DLY  = 4,
    parameter int unsigned TIMEOUT  = 65536
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       CH1,
    input  logic       CH2,
    input  logic [7:0] PA_I,
    output logic [7:0] PA_O,
    output logic [7:0] PA_OE,
    input  logic [7:0] PB_I,
    output logic [7:0] PB_O,
    output logic [7:0] PB_OE,
    output logic [7:0] SND_O
);

    localparam logic [1:0] S_IDLE = PKT_IDLE;
    localparam logic [1:0] S_B1   = PKT_B1;
    localparam logic [1:0] S_B2   = PKT_B2;
    localparam logic [1:0] S_B3   = PKT_B3;

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned DW = $clog2(DSB_DLY + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(DSB_DLY - 1);

    logic          wr;
    logic          wr_r;
    logic          wr_d;
    logic          strobe;
    logic [1:0]    state;
    logic          dsb;
    logic          dsb_pend;
    logic [DW-1:0] dly_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    timbre_s;
    logic [7:0]    period_s;
    logic          tone_load;
    logic          tone_stop;
    logic          unused_straps;

    assign unused_straps = ^{CH1, CH2, PB_I[5:0]};

    assign PA_O  = '0;
    assign PA_OE = '0;
    assign PB_OE = 8'h01;
    assign PB_O  = {7'd0, dsb};

    assign wr        = ~PB_I[7] & ~PB_I[6];
    assign strobe    = wr_r & ~wr_d;
    assign tone_load = strobe && (state == S_B3);
    assign tone_stop = strobe && (state == S_IDLE) && (PA_I == CMD_STOP);

    always_ff @(posedge CLK) begin
        if (RES) begin
            wr_r <= 1'b0;
            wr_d <= 1'b0;
        end else begin
            wr_r <= wr;
            wr_d <= wr_r;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state    <= S_IDLE;
            dsb      <= 1'b0;
            dsb_pend <= 1'b0;
            dly_cnt  <= '0;
            tmo_cnt  <= '0;
            timbre_s <= '0;
            period_s <= '0;
        end else if (strobe) begin
            dsb     <= 1'b0;
            dly_cnt <= '0;
            tmo_cnt <= '0;
            case (state)
                S_IDLE: begin
                    if (PA_I == CMD_TONE) begin
                        state    <= S_B1;
                        dsb_pend <= 1'b1;
                    end else begin
                        dsb_pend <= 1'b0;
                    end
                end
                S_B1: begin
                    timbre_s <= PA_I[7:5];
                    state    <= S_B2;
                    dsb_pend <= 1'b1;
                end
                S_B2: begin
                    period_s <= PA_I;
                    state    <= S_B3;
                    dsb_pend <= 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    dsb_pend <= 1'b0;
                end
            endcase
        end else if (state != S_IDLE) begin
            if (tmo_cnt == TMO_LAST) begin
                state    <= S_IDLE;
                dsb      <= 1'b0;
                dsb_pend <= 1'b0;
                tmo_cnt  <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
                // The DSB delay only runs once the host has released /WR.
                if (dsb_pend && !wr_r) begin
                    if (dly_cnt == DLY_LAST) begin
                        dsb      <= 1'b1;
                        dsb_pend <= 1'b0;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
            end
        end
    end

    upd1771c_tone #(
        .TICK_DIV (TICK_DIV)
    ) u_tone (
        .clk    (CLK),
        .res    (RES),
        .load   (tone_load),
        .stop   (tone_stop),
        .timbre (timbre_s),
        .period (period_s),
        .volume (PA_I[4:0]),
        .snd    (SND_O)
    );

endmodule

// File: tb/tb_upd_1771c.sv
// Self-checking bench for upd_1771c. A behavioural model decodes the
// written byte stream into tone events and computes the expected sample
// from elapsed time by plain division; a compare process checks SND_O
// every cycle. Directed steps pin DSB behaviour, stop, timeout abort
// and half-period lengths with literal values.
module tb_upd_1771c;

    localparam int TD  = 4;
    localparam int DLY = 4;
    localparam int TMO = 2048;

    logic       CLK;
    logic       RES;
    logic       CH1;
    logic       CH2;
    logic [7:0] PA_I;
    logic [7:0] PA_O;
    logic [7:0] PA_OE;
    logic [7:0] PB_I;
    logic [7:0] PB_O;
    logic [7:0] PB_OE;
    logic [7:0] SND_O;

    upd_1771c #(
        .TICK_DIV (TD),
        .DSB_DLY  (DLY),
        .TIMEOUT  (TMO)
    ) dut (
        .CLK   (CLK),
        .RES   (RES),
        .CH1   (CH1),
        .CH2   (CH2),
        .PA_I  (PA_I),
        .PA_O  (PA_O),
        .PA_OE (PA_OE),
        .PB_I  (PB_I),
        .PB_O  (PB_O),
        .PB_OE (PB_OE),
        .SND_O (SND_O)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    bit     cmp_en = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    typedef struct {
        longint eff;
        bit     stop;
        int     tim;
        int     per;
        int     vol;
    } ev_t;

    ev_t    evq[$];
    int     mst = 0;
    int     mtim = 0;
    int     mper = 0;
    longint mlast = 0;
    int     cur_tim = 0;
    int     cur_per = 0;
    int     cur_vol = 0;
    longint cur_load = 0;

    // Byte stream decoder; lat is the clock edge the byte takes effect.
    function automatic void model_byte(input int b, input longint lat);
        ev_t ev;
        if (mst != 0 && (lat - mlast) > TMO) mst = 0;
        mlast = lat;
        case (mst)
            0: begin
                if (b == 2) mst = 1;
                else if (b == 0) begin
                    ev.eff = lat; ev.stop = 1; ev.tim = 0; ev.per = 0; ev.vol = 0;
                    evq.push_back(ev);
                end
            end
            1: begin mtim = b / 32; mst = 2; end
            2: begin mper = b; mst = 3; end
            default: begin
                ev.eff = lat; ev.stop = 0; ev.tim = mtim; ev.per = mper; ev.vol = b % 32;
                evq.push_back(ev);
                mst = 0;
            end
        endcase
    endfunction

    function automatic int model_level(input int tim, input int ph);
        case (tim)
            1:       return (ph < 8) ? 7 : 0;
            2:       return (ph < 4) ? 7 : 0;
            3:       return ph / 4;
            4:       return (ph < 16) ? ph / 2 : (31 - ph) / 2;
            default: return (ph < 16) ? 7 : 0;
        endcase
    endfunction

    // The sample seen after edge E reflects tone state as of edge E-1.
    always @(negedge CLK) begin : compare
        ev_t    ev;
        longint d;
        int     ph;
        int     expv;
        if (cmp_en) begin
            while (evq.size() > 0 && evq[0].eff <= cyc - 1) begin
                ev = evq.pop_front();
                if (ev.stop) cur_per = 0;
                else begin
                    cur_tim = ev.tim; cur_per = ev.per; cur_vol = ev.vol; cur_load = ev.eff;
                end
            end
            if (cur_per == 0) expv = 0;
            else begin
                d    = cyc - 1 - cur_load;
                ph   = int'((d / longint'((cur_per + 1) * TD)) % 32);
                expv = model_level(cur_tim, ph) * cur_vol;
            end
            checks++;
            if (int'(SND_O) != expv || PA_O != 8'h00 || PA_OE != 8'h00 ||
                PB_OE != 8'h01 || PB_O[7:1] != 7'd0) begin
                errors++;
                $display("FAIL snd_model @%0d: SND_O=%0d required %0d (PA_O=%h PA_OE=%h PB_OE=%h PB_O=%h)",
                         cyc, SND_O, expv, PA_O, PA_OE, PB_OE, PB_O);
            end
        end
    end

    // ---------------- DSB rise monitor ----------------
    int dsb_rises = 0;
    bit dsb_prev = 0;
    always @(negedge CLK) begin
        if (PB_O[0] && !dsb_prev) dsb_rises++;
        dsb_prev = PB_O[0];
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // PA_I is held after release so the byte is stable when latched.
    task automatic write_byte(input logic [7:0] b, input int w);
        @(negedge CLK);
        PA_I = b;
        PB_I = {2'b00, 6'($urandom)};
        model_byte(int'(b), cyc + 2);
        repeat (w) @(negedge CLK);
        PB_I = {2'b11, 6'($urandom)};
        @(negedge CLK);
    endtask

    task automatic wait_dsb(input string tag);
        int k;
        k = 0;
        while (PB_O[0] !== 1'b1 && k < 200) begin
            @(negedge CLK);
            k++;
        end
        checks++;
        if (PB_O[0] !== 1'b1) begin
            errors++;
            $display("FAIL %s dsb_wait: DSB=%b required 1 within 200 clk", tag, PB_O[0]);
        end
    endtask

    task automatic measure(input logic [7:0] v, output int n);
        int k;
        k = 0;
        n = 0;
        while (SND_O !== v && k < 100) begin
            @(negedge CLK);
            k++;
        end
        while (SND_O === v && n < 30000) begin
            n++;
            @(negedge CLK);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int r0;
        int n;
        RES  = 1'b1;
        CH1  = 1'b1;
        CH2  = 1'b0;
        PA_I = 8'h00;
        PB_I = 8'hFF;
        repeat (5) @(negedge CLK);
        RES    = 1'b0;
        cmp_en = 1;
        repeat (10) @(negedge CLK);

        check("reset_dsb",   PB_O, 8'h00);
        check("reset_snd",   SND_O, 8'h00);
        check("reset_pb_oe", PB_OE, 8'h01);
        check("reset_pa_oe", PA_OE, 8'h00);

        // Packet 02 80 35 15; the last two bytes go back-to-back so DSB
        // has no time to rise between them.
        r0 = dsb_rises;
        write_byte(8'h02, 2); wait_dsb("pktA_b0");
        write_byte(8'h80, 3); wait_dsb("pktA_b1");
        write_byte(8'h35, 1);
        write_byte(8'h15, 1);
        repeat (50) @(negedge CLK);
        check("pktA_dsb_rises", dsb_rises - r0, 2);
        check("pktA_dsb_final", PB_O[0], 0);
        repeat (1000) @(negedge CLK);

        // Stop mid-tone.
        r0 = dsb_rises;
        write_byte(8'h00, 3);
        check("stop_snd", SND_O, 8'h00);
        repeat (30) @(negedge CLK);
        check("stop_no_dsb", dsb_rises - r0, 0);

        // Square, P=0x35, V=0x15: half period 16*54*TD = 3456.
        write_byte(8'h02, 2); wait_dsb("pktB_b0");
        write_byte(8'h1F, 2); wait_dsb("pktB_b1");
        write_byte(8'h35, 2); wait_dsb("pktB_b2");
        write_byte(8'h15, 1);
        check("pktB_level", SND_O, 8'h00);
        measure(8'h93, n);
        check("pktB_high_half", n, 3456);
        measure(8'h00, n);
        check("pktB_low_half", n, 3456);

        // Square, P=0x4F: half period 16*80*TD = 5120.
        write_byte(8'h00, 1);
        write_byte(8'h02, 2); wait_dsb("pktC_b0");
        write_byte(8'h1F, 2); wait_dsb("pktC_b1");
        write_byte(8'h4F, 2); wait_dsb("pktC_b2");
        write_byte(8'h15, 1);
        measure(8'h93, n);
        check("pktC_high_half", n, 5120);

        // Incomplete packet aborts after TIMEOUT; tone C keeps playing.
        write_byte(8'h02, 2); wait_dsb("tmo_b0");
        write_byte(8'h60, 2); wait_dsb("tmo_b1");
        repeat (TMO - 100) @(negedge CLK);
        check("tmo_dsb_before", PB_O[0], 1);
        repeat (200) @(negedge CLK);
        check("tmo_dsb_after", PB_O[0], 0);
        r0 = dsb_rises;
        write_byte(8'h15, 2);
        repeat (20) @(negedge CLK);
        check("tmo_idle_byte_dsb", dsb_rises - r0, 0);

        // Unknown byte in IDLE is ignored, next packet decodes normally.
        write_byte(8'h7E, 2);
        repeat (20) @(negedge CLK);
        check("junk_dsb", dsb_rises - r0, 0);
        write_byte(8'h02, 2); wait_dsb("pktD_b0");
        write_byte(8'hA0, 2); wait_dsb("pktD_b1");
        write_byte(8'h07, 2); wait_dsb("pktD_b2");
        write_byte(8'h1F, 2);
        repeat (500) @(negedge CLK);

        // Randomized traffic.
        for (int i = 0; i < 16; i++) begin
            int         sel;
            logic [7:0] jb;
            logic [7:0] pk [4];
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                write_byte(8'h00, $urandom_range(1, 4));
            end else if (sel == 1) begin
                jb = 8'($urandom);
                if (jb == 8'h00 || jb == 8'h02) jb = 8'h7E;
                write_byte(jb, $urandom_range(1, 4));
            end else begin
                pk[0] = 8'h02;
                pk[1] = 8'($urandom);
                pk[2] = 8'($urandom_range(0, 12));
                pk[3] = 8'($urandom);
                for (int j = 0; j < 4; j++) begin
                    write_byte(pk[j], $urandom_range(1, 5));
                    if (j < 3) begin
                        if ($urandom_range(0, 1) == 1) wait_dsb("rand");
                        else repeat ($urandom_range(0, 6)) @(negedge CLK);
                    end
                end
            end
            repeat ($urandom_range(100, 1200)) @(negedge CLK);
        end

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
